// File: rtl/athos_ip_pkg.sv
// Shared athos_ip definitions: op codes, scheduler state encodings and per-op compute latencies.
package athos_ip_pkg;

    typedef enum logic [5:0] {
        OP_NULL   = 6'd0,
        OP_KECCAK = 6'd1,
        OP_NTT    = 6'd2,
        OP_INTT   = 6'd3,
        OP_TRNG   = 6'd4
    } athos_op_t;

    typedef logic [3:0] sched_state_t;

    localparam sched_state_t S_IDLE         = 4'd0;
    localparam sched_state_t S_LOAD         = 4'd1;
    localparam sched_state_t S_LOAD_DATA    = 4'd2;
    localparam sched_state_t S_COMPUTE      = 4'd3;
    localparam sched_state_t S_COMPUTE_WAIT = 4'd4;
    localparam sched_state_t S_STORE        = 4'd5;
    localparam sched_state_t S_STORE_WAIT   = 4'd6;
    localparam sched_state_t S_DONE_WAIT    = 4'd7;
    localparam sched_state_t S_CPL          = 4'd8;

    localparam int unsigned KECCAK_CYC = 25;
    localparam int unsigned NTT_CYC    = 907;
    localparam int unsigned INTT_CYC   = 907;
    localparam int unsigned TRNG_CYC   = 513;

    function automatic logic [9:0] op_latency(input logic [5:0] op);
        case (op)
            OP_KECCAK: return 10'(KECCAK_CYC);
            OP_NTT:    return 10'(NTT_CYC);
            OP_INTT:   return 10'(INTT_CYC);
            OP_TRNG:   return 10'(TRNG_CYC);
            default:   return 10'd1;
        endcase
    endfunction

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == '1) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/athos_ip_rr_arb.sv
// Round-robin arbiter: first request at or after the pointer wins; pointer moves past the winner on enable.
module athos_ip_rr_arb #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] cand;

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IW'((32'(ptr_q) + i) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
        gnt_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (en_i && any_o) begin
            ptr_q <= (idx_o == IW'(NUM_REQ - 1)) ? '0 : idx_o + IW'(1);
        end
    end

endmodule

// File: rtl/athos_ip_sched.sv
// Round-robin job scheduler sequencing the athos_ip control unit through LOAD/COMPUTE/STORE.
// Optional done timeout: define ATHOS_SCHED_TIMEOUT_EN.
module athos_ip_sched
    import athos_ip_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned LOAD_BEATS   = 256,
    parameter int unsigned STORE_BEATS  = 256,
    parameter int unsigned DONE_TIMEOUT = 1024,
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*6-1:0] req_op_i,
    input  logic [NUM_REQ-1:0]   req_load_i,
    input  logic [NUM_REQ-1:0]   req_store_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic [NUM_REQ-1:0]   beat_valid_i,
    output logic [NUM_REQ-1:0]   beat_ready_o,
    output logic [IW-1:0]        owner_o,
    output logic                 busy_o,
    output logic [NUM_REQ-1:0]   cpl_o,
    output logic                 cpl_err_o,
    output logic                 cu_load_o,
    output logic                 cu_start_o,
    output logic                 cu_store_o,
    output logic                 cu_load_en_o,
    output logic [5:0]           cu_op_o,
    input  logic                 cu_done_i
);

    if (LOAD_BEATS < 1 || LOAD_BEATS > 1023 || STORE_BEATS < 1 || STORE_BEATS > 1023) begin : g_beats_chk
        $error("athos_ip_sched: LOAD_BEATS/STORE_BEATS must be in 1..1023");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8 || DONE_TIMEOUT < 1 || DONE_TIMEOUT > 1024) begin : g_cfg_chk
        $error("athos_ip_sched: NUM_REQ must be 2..8 and DONE_TIMEOUT 1..1024");
    end

    sched_state_t state_q, state_d;
    logic [9:0]   cnt_q, cnt_d;
    logic [5:0]   op_q;
    logic         store_q;
    logic [IW-1:0] owner_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_any;
    logic               grant;
    logic [NUM_REQ-1:0] owner_oh;
    logic               beat_hit;
    logic [5:0]         op_arr [NUM_REQ];

    athos_ip_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req_valid_i),
        .en_i  (state_q == S_IDLE),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            op_arr[i] = req_op_i[i*6 +: 6];
        end
    end

    assign grant    = arb_any && (state_q == S_IDLE);
    assign owner_oh = NUM_REQ'(1) << owner_q;
    assign beat_hit = (state_q == S_LOAD_DATA) && beat_valid_i[owner_q];

`ifdef ATHOS_SCHED_TIMEOUT_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef ATHOS_SCHED_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant) begin
`ifdef ATHOS_SCHED_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    if (req_load_i[arb_idx])
                        state_d = S_LOAD;
                    else if (op_arr[arb_idx] == OP_NULL)
                        state_d = req_store_i[arb_idx] ? S_STORE : S_CPL;
                    else
                        state_d = S_COMPUTE;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_LOAD_DATA;
            end
            S_LOAD_DATA: begin
                if (beat_hit) begin
                    if (cnt_q >= 10'(LOAD_BEATS - 1)) begin
                        cnt_d = '0;
                        if (op_q == OP_NULL)
                            state_d = store_q ? S_STORE : S_CPL;
                        else
                            state_d = S_COMPUTE;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
            end
            // Loading latency-1 makes cu_start_o -> leaving COMPUTE_WAIT span exactly the op latency.
            S_COMPUTE: begin
                cnt_d   = op_latency(op_q) - 10'd1;
                state_d = S_COMPUTE_WAIT;
            end
            S_COMPUTE_WAIT: begin
                if (cnt_q <= 10'd1) begin
                    cnt_d   = '0;
                    state_d = store_q ? S_STORE : S_CPL;
                end else begin
                    cnt_d = cnt_q - 10'd1;
                end
            end
            S_STORE: begin
                cnt_d   = '0;
                state_d = S_STORE_WAIT;
            end
            S_STORE_WAIT: begin
                if (cnt_q >= 10'(STORE_BEATS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE_WAIT;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_DONE_WAIT: begin
                if (cu_done_i) begin
                    state_d = S_CPL;
                end
`ifdef ATHOS_SCHED_TIMEOUT_EN
                else if (cnt_q >= 10'(DONE_TIMEOUT - 1)) begin
                    state_d = S_CPL;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
`endif
            end
            S_CPL:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            store_q <= 1'b0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                op_q    <= op_arr[arb_idx];
                store_q <= req_store_i[arb_idx];
                owner_q <= arb_idx;
            end
        end
    end

`ifdef ATHOS_SCHED_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign cpl_err_o = (state_q == S_CPL) && err_q;
`else
    assign cpl_err_o = 1'b0;
`endif

    assign req_ready_o  = grant ? arb_gnt : '0;
    assign beat_ready_o = (state_q == S_LOAD_DATA) ? (beat_valid_i & owner_oh) : '0;
    assign cu_load_en_o = beat_hit;
    assign owner_o      = owner_q;
    assign busy_o       = (state_q != S_IDLE);
    assign cpl_o        = (state_q == S_CPL) ? owner_oh : '0;
    assign cu_load_o    = (state_q == S_LOAD);
    assign cu_start_o   = (state_q == S_COMPUTE);
    assign cu_store_o   = (state_q == S_STORE);
    assign cu_op_o      = busy_o ? op_q : '0;

endmodule

// File: tb/tb_athos_ip_sched.sv
// Scoreboard bench for athos_ip_sched: expected jobs queued at request time, checked at each cpl pulse.
module tb_athos_ip_sched;
    import athos_ip_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned TMO  = 16;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [NREQ-1:0]   req_valid_i = '0;
    logic [NREQ*6-1:0] req_op_i = '0;
    logic [NREQ-1:0]   req_load_i = '0;
    logic [NREQ-1:0]   req_store_i = '0;
    logic [NREQ-1:0]   req_ready_o;
    logic [NREQ-1:0]   beat_valid_i = '0;
    logic [NREQ-1:0]   beat_ready_o;
    logic [0:0]        owner_o;
    logic              busy_o;
    logic [NREQ-1:0]   cpl_o;
    logic              cpl_err_o;
    logic              cu_load_o, cu_start_o, cu_store_o, cu_load_en_o;
    logic [5:0]        cu_op_o;
    logic              cu_done_i = 1'b0;

    athos_ip_sched #(
        .NUM_REQ      (NREQ),
        .LOAD_BEATS   (256),
        .STORE_BEATS  (256),
        .DONE_TIMEOUT (TMO)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_op_i     (req_op_i),
        .req_load_i   (req_load_i),
        .req_store_i  (req_store_i),
        .req_ready_o  (req_ready_o),
        .beat_valid_i (beat_valid_i),
        .beat_ready_o (beat_ready_o),
        .owner_o      (owner_o),
        .busy_o       (busy_o),
        .cpl_o        (cpl_o),
        .cpl_err_o    (cpl_err_o),
        .cu_load_o    (cu_load_o),
        .cu_start_o   (cu_start_o),
        .cu_store_o   (cu_store_o),
        .cu_load_en_o (cu_load_en_o),
        .cu_op_o      (cu_op_o),
        .cu_done_i    (cu_done_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int        owner;
        logic [5:0] op;
        int        n_load, n_beats, n_start, n_store;
        int        lat, span, st_lat, done_lat;
        int        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_pass = 0, cyc = 0;
    int   m_load, m_beats, m_start, m_store, m_opbad, m_excl, m_xbeat;
    int   m_start_t, m_store_t, m_done_t, m_first, m_last, m_gidx;
    bit   beat_mode = 1'b0;
    bit   beat1 = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Requester 0 beats are continuous or alternate each cycle; requester 1 is a constant level.
    initial forever begin
        @(posedge clk_i); #1;
        beat_valid_i[0] = beat_mode ? ~beat_valid_i[0] : 1'b1;
        beat_valid_i[1] = beat1;
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (req_ready_o != '0) begin
                chk("ready_onehot", $onehot(req_ready_o), 1);
                m_gidx = req_ready_o[1] ? 1 : 0;
                if (exp_q.size() == 0) chk("grant_unexpected", exp_q.size(), 1);
                else chk("grant_owner", m_gidx, exp_q[0].owner);
                m_load = 0; m_beats = 0; m_start = 0; m_store = 0;
                m_opbad = 0; m_excl = 0; m_xbeat = 0; m_first = -1; m_last = -1;
                m_start_t = 0; m_store_t = 0; m_done_t = 0;
            end
            if (busy_o) begin
                if (exp_q.size() > 0 && cu_op_o != exp_q[0].op) m_opbad++;
                if (int'(cu_load_o) + int'(cu_start_o) + int'(cu_store_o) > 1) m_excl++;
                if ((beat_ready_o & ~(NREQ'(1) << owner_o)) != '0) m_xbeat++;
                if (cu_load_o) m_load++;
                if (cu_load_en_o) begin
                    m_beats++;
                    if (m_first < 0) m_first = cyc;
                    m_last = cyc;
                end
                if (cu_start_o) begin m_start++; m_start_t = cyc; end
                if (cu_store_o) begin m_store++; m_store_t = cyc; end
                if (cu_done_i) m_done_t = cyc;
            end
            if (cpl_o != '0) begin
                if (exp_q.size() == 0) begin
                    chk("cpl_unexpected", exp_q.size(), 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("cpl_vec", cpl_o, NREQ'(1) << e.owner);
                    chk("cpl_err", cpl_err_o, e.err);
                    chk("owner_o", owner_o, e.owner);
                    chk("op_hold", m_opbad, 0);
                    chk("cu_exclusive", m_excl, 0);
                    chk("beat_ready_other", m_xbeat, 0);
                    chk("load_pulses", m_load, e.n_load);
                    chk("load_beats", m_beats, e.n_beats);
                    chk("start_pulses", m_start, e.n_start);
                    chk("store_pulses", m_store, e.n_store);
                    if (e.lat > 0) chk("start_to_cpl", cyc - m_start_t, e.lat);
                    if (e.span > 0) chk("beat_span", m_last - m_first, e.span);
                    if (e.st_lat > 0) chk("store_to_cpl", cyc - m_store_t, e.st_lat);
                    if (e.done_lat > 0) chk("done_to_cpl", cyc - m_done_t, e.done_lat);
                end
            end
        end
    end

    task automatic push(input int owner, input logic [5:0] op, input int ld, input int st,
                        input int lat, input int span, input int st_lat, input int done_lat, input int err);
        exp_t e;
        e.owner = owner; e.op = op;
        e.n_load = ld; e.n_beats = ld * 256;
        e.n_start = (op != OP_NULL) ? 1 : 0; e.n_store = st;
        e.lat = lat; e.span = span; e.st_lat = st_lat; e.done_lat = done_lat; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic request(input int r, input logic [5:0] op, input bit ld, input bit st);
        int got;
        got = 0;
        @(posedge clk_i); #1;
        req_op_i[r*6 +: 6] = op;
        req_load_i[r] = ld;
        req_store_i[r] = st;
        req_valid_i[r] = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk_i);
            if (req_ready_o[r]) begin got = 1; break; end
        end
        chk("ready_wait", got, 1);
        @(posedge clk_i); #1;
        req_valid_i[r] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk_i); #1;
            if (exp_q.size() == 0 && !busy_o) break;
        end
        chk("idle_wait", exp_q.size() + int'(busy_o), 0);
    endtask

    task automatic wait_store(output int seen);
        seen = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk_i);
            if (cu_store_o) begin seen = 1; break; end
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({req_ready_o, beat_ready_o, owner_o, busy_o, cpl_o, cpl_err_o,
                    cu_load_o, cu_start_o, cu_store_o, cu_load_en_o, cu_op_o});
    endfunction

    initial begin
        int seen;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_outputs", out_vec(), 0);
        @(posedge clk_i); #1 rst_i = 1'b0;

        // Contention from pointer 0: expect 0,1,0,1
        for (int k = 0; k < 2; k++) begin
            push(0, OP_KECCAK, 0, 0, 25, 0, 0, 0, 0);
            push(1, OP_KECCAK, 0, 0, 25, 0, 0, 0, 0);
        end
        fork
            begin request(0, OP_KECCAK, 0, 0); request(0, OP_KECCAK, 0, 0); end
            begin request(1, OP_KECCAK, 0, 0); request(1, OP_KECCAK, 0, 0); end
        join
        wait_idle();

        // Single requester KECCAK with back-to-back beats
        push(0, OP_KECCAK, 1, 0, 25, 255, 0, 0, 0);
        request(0, OP_KECCAK, 1, 0);
        wait_idle();

        // NTT with alternating beats, requester 1 beat_valid held high
        beat_mode = 1'b1; beat1 = 1'b1;
        push(0, OP_NTT, 1, 0, 907, 510, 0, 0, 0);
        request(0, OP_NTT, 1, 0);
        wait_idle();
        beat_mode = 1'b0; beat1 = 1'b0;

        // Store path, done 3 cycles into DONE_WAIT
        push(1, OP_NTT, 0, 1, 0, 0, 261, 1, 0);
        request(1, OP_NTT, 0, 1);
        wait_store(seen);
        chk("store_seen", seen, 1);
        repeat (260) @(posedge clk_i);
        #1 cu_done_i = 1'b1;
        @(posedge clk_i); #1 cu_done_i = 1'b0;
        wait_idle();

        // done never arrives
`ifdef ATHOS_SCHED_TIMEOUT_EN
        push(0, OP_KECCAK, 0, 1, 0, 0, 256 + 1 + TMO, 0, 1);
        request(0, OP_KECCAK, 0, 1);
        wait_idle();
`else
        push(0, OP_KECCAK, 0, 1, 0, 0, 0, 0, 0);
        request(0, OP_KECCAK, 0, 1);
        wait_store(seen);
        chk("store_seen_hang", seen, 1);
        repeat (300) @(negedge clk_i);
        chk("busy_hang", busy_o, 1);
        #1 rst_i = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
`endif

        // Reset during LOAD_DATA at beat 100 of a requester-0 job
        push(0, OP_NTT, 1, 0, 0, 0, 0, 0, 0);
        request(0, OP_NTT, 1, 0);
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_i); #1;
            if (m_beats >= 100) begin seen = 1; break; end
        end
        chk("beat100_seen", seen, 1);
        rst_i = 1'b1;
        exp_q.delete();
        @(negedge clk_i);
        chk("midjob_reset_outputs", out_vec(), 0);
        chk("midjob_reset_busy", busy_o, 0);
        @(posedge clk_i); #1 rst_i = 1'b0;

        // Pointer back at 0: simultaneous requests grant 0 then 1
        push(0, OP_KECCAK, 0, 0, 25, 0, 0, 0, 0);
        push(1, OP_KECCAK, 0, 0, 25, 0, 0, 0, 0);
        fork
            request(0, OP_KECCAK, 0, 0);
            request(1, OP_KECCAK, 0, 0);
        join
        wait_idle();

        repeat (5) @(negedge clk_i);
        chk("final_idle", busy_o, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected 0", 1);
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "timeout");
    end

endmodule
